// File: rtl/mux_scan_sampler_if.sv
// Selector-side bus of the mux scan sampler: scan control, selector drive/readback, result.
// Ports: START/ABORT/Q/Q_N into the sampler; SEL/CE_N/BUSY/DONE/DATA/ERR out of it.
interface mux_scan_sampler_if;
  logic       START;
  logic       ABORT;
  logic       Q;
  logic       Q_N;
  logic [2:0] SEL;
  logic       CE_N;
  logic       BUSY;
  logic       DONE;
  logic [7:0] DATA;
  logic       ERR;

  modport slave (
    input  START, ABORT, Q, Q_N,
    output SEL, CE_N, BUSY, DONE, DATA, ERR
  );

  modport master (
    output START, ABORT, Q, Q_N,
    input  SEL, CE_N, BUSY, DONE, DATA, ERR
  );
endinterface

// File: rtl/mux_scan_sampler.sv
// Steps an external 8:1 selector through codes 0..7, samples Q after a settle time, reports DATA/ERR.
// Ports: CLK, RESET_N (async active-low), bus (slave modport: START/ABORT/Q/Q_N in, SEL/CE_N/BUSY/DONE/DATA/ERR out).
module mux_scan_sampler #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                CLK,
  input  logic                RESET_N,
  mux_scan_sampler_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shadow_q, shadow_d;
  logic       mis_q, mis_d;
  logic [7:0] data_q, data_d;
  logic       err_q, err_d;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      sel_q    <= 3'd0;
      cnt_q    <= 4'd0;
      shadow_q <= 8'd0;
      mis_q    <= 1'b0;
      data_q   <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      mis_q    <= mis_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    mis_d    = mis_q;
    data_d   = data_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.START && !bus.ABORT) begin
          state_d  = S_SETTLE;
          sel_d    = 3'd0;
          cnt_d    = RELOAD;
          shadow_d = 8'd0;
          mis_d    = 1'b0;
          err_d    = 1'b0;
        end
      end
      S_SETTLE: begin
        if (bus.ABORT) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SAMPLE: begin
        if (bus.ABORT) begin
          state_d = S_IDLE;
        end else begin
          shadow_d[sel_q] = bus.Q;
          mis_d = mis_q | (bus.Q == bus.Q_N);
          if (sel_q == 3'd7) begin
            // Publish includes the bit-7 sample taken on this same edge.
            state_d = S_DONE;
            data_d  = shadow_d;
            err_d   = mis_d;
          end else begin
            state_d = S_SETTLE;
            sel_d   = sel_q + 3'd1;
            cnt_d   = RELOAD;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.SEL  = sel_q;
  assign bus.BUSY = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign bus.CE_N = !bus.BUSY;
  assign bus.DONE = (state_q == S_DONE);
  assign bus.DATA = data_q;
  assign bus.ERR  = err_q;

endmodule
